sdtrl_timing_ring: RTL

- Parametrised successor to the hard-wired SDTRL oscillator, binary-trigger and MUP trigger-ring timing chain.
- Divides a qualified oscillator enable by DIV and drives an N_STAGES one-hot timing ring (T-pulses) that sequences memory/CPU cycles.
- Adds continuous, single-cycle and single-step modes, clean stop at the cycle boundary, a half-period phase output and a cycle counter.
- Sits between the oscillator card model and the cycle-control logic.

---
 rtl/sdtrl_timing_ring.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/sdtrl_timing_ring.sv
// SDTRL timing chain: qualified oscillator divider driving a one-hot T-pulse ring
// with continuous, single-cycle and single-step sequencing plus a cycle counter.
module sdtrl_timing_ring #(
  parameter int unsigned N_STAGES = 10,
  parameter int unsigned DIV      = 2,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                SYSCLOCK,
  input  logic                RESET,
  input  logic                osc_en,
  input  logic [1:0]          mode,
  input  logic                start_req,
  input  logic                stop_req,
  input  logic                step_req,
  output logic [N_STAGES-1:0] t_ring,
  output logic                t_early,
  output logic                cycle_end,
  output logic                running,
  output logic [CNT_W-1:0]    cycle_count
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DIV_W-1:0]    DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [DIV_W-1:0]    DIV_HALF   = DIV_W'(DIV / 2);
  localparam logic [N_STAGES-1:0] RING_FIRST = N_STAGES'(1);

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RUN       = 2'b01,
    STEP_WAIT = 2'b10
  } state_t;

  typedef enum logic [1:0] {
    MODE_CONT   = 2'b00,
    MODE_SINGLE = 2'b01,
    MODE_STEP   = 2'b10
  } mode_t;

  state_t              state_q, state_d;
  mode_t               mode_q, mode_d, mode_in;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [N_STAGES-1:0] ring_d;
  logic [CNT_W-1:0]    cnt_d;
  logic                start_pend_q, start_pend_d;
  logic                stop_pend_q, stop_pend_d;
  logic                step_pend_q, step_pend_d;
  logic                start_eff, stop_eff, step_eff;
  logic                adv, at_last, do_step, to_idle;
  logic                cend_d, early_d;

  assign running = (state_q != IDLE);
  assign at_last = t_ring[N_STAGES-1];

  always_comb begin
    div_d = div_q;
    adv   = 1'b0;
    if (osc_en) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        adv   = 1'b1;
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end

    unique case (mode)
      2'b01:   mode_in = MODE_SINGLE;
      2'b10:   mode_in = MODE_STEP;
      default: mode_in = MODE_CONT;
    endcase

    start_eff = start_pend_q | start_req;
    stop_eff  = stop_pend_q  | stop_req;
    step_eff  = step_pend_q  | step_req;

    state_d      = state_q;
    mode_d       = mode_q;
    ring_d       = t_ring;
    cnt_d        = cycle_count;
    start_pend_d = start_eff;
    stop_pend_d  = stop_eff;
    step_pend_d  = step_eff;
    cend_d       = 1'b0;
    do_step      = 1'b0;
    to_idle      = 1'b0;

    unique case (state_q)
      IDLE: begin
        step_pend_d = 1'b0;
        if (stop_eff) begin
          start_pend_d = 1'b0;
          stop_pend_d  = 1'b0;
        end else if (adv && start_eff) begin
          mode_d       = mode_in;
          ring_d       = RING_FIRST;
          start_pend_d = 1'b0;
          state_d      = (mode_in == MODE_STEP) ? STEP_WAIT : RUN;
        end
      end
      RUN: begin
        start_pend_d = 1'b0;
        step_pend_d  = 1'b0;
        do_step      = adv;
      end
      STEP_WAIT: begin
        start_pend_d = 1'b0;
        if (adv) begin
          if (stop_eff) begin
            to_idle = 1'b1;
          end else if (step_eff) begin
            do_step     = 1'b1;
            step_pend_d = 1'b0;
          end
        end
      end
      default: to_idle = 1'b1;
    endcase

    // Shared stage advance; stop in STEP_WAIT is resolved above, so here it only ends a full pass.
    if (do_step) begin
      if (at_last) begin
        cend_d = 1'b1;
        cnt_d  = cycle_count + CNT_W'(1);
        if (mode_q == MODE_SINGLE || stop_eff) begin
          to_idle = 1'b1;
        end else begin
          mode_d  = mode_in;
          ring_d  = RING_FIRST;
          state_d = (mode_in == MODE_STEP) ? STEP_WAIT : RUN;
        end
      end else begin
        ring_d = t_ring << 1;
      end
    end

    if (to_idle) begin
      state_d      = IDLE;
      ring_d       = '0;
      start_pend_d = 1'b0;
      stop_pend_d  = 1'b0;
      step_pend_d  = 1'b0;
    end

    early_d = (ring_d != '0) && (div_d < DIV_HALF);
  end

  always_ff @(posedge SYSCLOCK or posedge RESET) begin
    if (RESET) begin
      state_q      <= IDLE;
      mode_q       <= MODE_CONT;
      div_q        <= '0;
      start_pend_q <= 1'b0;
      stop_pend_q  <= 1'b0;
      step_pend_q  <= 1'b0;
      t_ring       <= '0;
      t_early      <= 1'b0;
      cycle_end    <= 1'b0;
      cycle_count  <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      div_q        <= div_d;
      start_pend_q <= start_pend_d;
      stop_pend_q  <= stop_pend_d;
      step_pend_q  <= step_pend_d;
      t_ring       <= ring_d;
      t_early      <= early_d;
      cycle_end    <= cend_d;
      cycle_count  <= cnt_d;
    end
  end

endmodule
